vpu_sram_rd_responder: RTL and testbench

VPU_SRAM_RD_RESPONDER -- requirements
Module: vpu_sram_rd_responder

---
 rtl/vpu_sram_rd_responder.sv | 114 +++++++++++
 tb/tb_vpu_sram_rd_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_sram_rd_responder.sv
// Read-port responder for a banked vector SRAM: grants one requester at a time,
// forwards burst beats to the latched bank and returns data after RD_LAT cycles.
module vpu_sram_rd_responder #(
    parameter int BANK_CNT_LG2   = 2,
    parameter int BANK_DEPTH_LG2 = 10,
    parameter int DATA_W         = 512,
    parameter int RD_LAT         = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req,
    output logic                                  ack,
    input  logic [BANK_CNT_LG2-1:0]               rid,
    input  logic [BANK_DEPTH_LG2-1:0]             addr,
    input  logic                                  reb,
    input  logic                                  rlast,
    output logic [DATA_W-1:0]                     rdata,
    output logic                                  rvalid,
    output logic [(2**BANK_CNT_LG2)-1:0]          mem_cs,
    output logic [BANK_DEPTH_LG2-1:0]             mem_addr,
    input  logic [(2**BANK_CNT_LG2)*DATA_W-1:0]   mem_rdata,
    output logic                                  busy
);

    localparam int BANK_CNT = 2**BANK_CNT_LG2;
    localparam int CNT_W    = $clog2(RD_LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [BANK_CNT_LG2-1:0] bank;
    logic                    beat;
    logic [RD_LAT-1:0]       vpipe;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [DATA_W-1:0]       bank_data;

    assign beat      = (state == BURST) && !reb;
    assign ack       = (state == GRANT);
    assign busy      = (state != IDLE);
    assign mem_addr  = addr;
    assign mem_cs    = beat ? (BANK_CNT'(1) << bank) : '0;
    assign bank_data = mem_rdata[int'(bank)*DATA_W +: DATA_W];
    assign rvalid    = vpipe[RD_LAT-1];
    assign cnt_nxt   = cnt + CNT_W'(beat) - CNT_W'(rvalid);

    // DRAIN leaves on the cycle the final outstanding beat is returned.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = GRANT;
            GRANT:   state_nxt = BURST;
            BURST:   if (beat && rlast) state_nxt = DRAIN;
            DRAIN:   if (cnt_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bank  <= '0;
            cnt   <= '0;
            vpipe <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) bank <= rid;
            cnt   <= cnt_nxt;
            vpipe <= (vpipe << 1) | RD_LAT'(beat);
        end
    end

    // vpipe[0] lines up with the macro output; later stages carry the word onward.
    if (RD_LAT == 1) begin : g_lat1
        logic [DATA_W-1:0] hold;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold <= '0;
            end else if (vpipe[0]) begin
                hold <= bank_data;
            end
        end

        assign rdata = vpipe[0] ? bank_data : hold;
    end else begin : g_latn
        logic [DATA_W-1:0] dpipe [RD_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned j = 0; j < unsigned'(RD_LAT - 1); j++) dpipe[j] <= '0;
            end else begin
                if (vpipe[0]) dpipe[0] <= bank_data;
                for (int unsigned j = 1; j < unsigned'(RD_LAT - 1); j++) begin
                    if (vpipe[j]) dpipe[j] <= dpipe[j-1];
                end
            end
        end

        assign rdata = dpipe[RD_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rvalid && cnt == '0));
            assert (!(beat && !rvalid && cnt == CNT_W'(RD_LAT)));
        end
    end

endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// Self-checking bench for vpu_sram_rd_responder: directed table, hand sequences,
// randomized traffic against a timestamp-based transaction model.
module tb_vpu_sram_rd_responder;

    localparam int RD_LAT = 3;
    localparam int INF    = 32'h7fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req, ack, reb, rlast, rvalid, busy;
    logic [1:0]    rid;
    logic [9:0]    addr, mem_addr;
    logic [511:0]  rdata;
    logic [3:0]    mem_cs;
    logic [2047:0] mem_rdata;

    logic          req1, ack1, reb1, rlast1, rvalid1, busy1;
    logic [1:0]    rid1;
    logic [9:0]    addr1, mem_addr1;
    logic [511:0]  rdata1;
    logic [3:0]    mem_cs1;
    logic [2047:0] mem_rdata1;

    vpu_sram_rd_responder #(.BANK_CNT_LG2(2), .BANK_DEPTH_LG2(10), .DATA_W(512), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .rid(rid), .addr(addr), .reb(reb),
        .rlast(rlast), .rdata(rdata), .rvalid(rvalid), .mem_cs(mem_cs), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    vpu_sram_rd_responder #(.BANK_CNT_LG2(2), .BANK_DEPTH_LG2(10), .DATA_W(512), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ack(ack1), .rid(rid1), .addr(addr1), .reb(reb1),
        .rlast(rlast1), .rdata(rdata1), .rvalid(rvalid1), .mem_cs(mem_cs1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [511:0] pat(input int b, input int a);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'hA500_0000 ^ (b << 24) ^ (a << 12) ^ (i * 32'h11);
        return r;
    endfunction

    function automatic logic [511:0] junk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // SRAM macros: data one cycle after chip-select, garbage otherwise
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) mem_rdata[b*512 +: 512] <= mem_cs[b] ? pat(b, int'(mem_addr)) : junk();
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) mem_rdata1[b*512 +: 512] <= mem_cs1[b] ? pat(b, int'(mem_addr1)) : junk();
    end

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    // transaction model: return timestamps and busy window
    typedef struct { int due; logic [511:0] data; } ret_t;
    ret_t         ret_q[$];
    int           busy_from = 0, busy_to = -1, ack_cyc = -10;
    bit           burst_open = 1'b0;
    logic [1:0]   bank_m = '0;
    logic [511:0] e_rdata = '0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ret_q.delete();
        busy_to = -1; busy_from = 0; ack_cyc = -10;
        burst_open = 1'b0; bank_m = '0; e_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk); cyc++; @(negedge clk);
    endtask

    task automatic tick(input bit rq, input logic [1:0] id, input bit rb, input bit rl, input logic [9:0] ad);
        bit         e_busy, e_ack, e_rv, acc;
        logic [3:0] e_cs;
        req = rq; rid = id; reb = rb; rlast = rl; addr = ad;
        #1;
        e_busy = (cyc >= busy_from) && (cyc <= busy_to);
        e_ack  = (cyc == ack_cyc);
        e_rv   = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        if (e_rv) begin
            e_rdata = ret_q[0].data;
            void'(ret_q.pop_front());
        end
        acc  = !rb && burst_open && (cyc > ack_cyc);
        e_cs = acc ? (4'b0001 << bank_m) : 4'b0000;
        chk("ack", ack, e_ack);
        chk("busy", busy, e_busy);
        chk("mem_cs", mem_cs, e_cs);
        if (acc) chk("mem_addr", mem_addr, ad);
        chk("rvalid", rvalid, e_rv);
        chk("rdata", rdata, e_rdata);
        if (acc) begin
            ret_q.push_back('{cyc + RD_LAT, pat(int'(bank_m), int'(ad))});
            if (rl) begin
                burst_open = 1'b0;
                busy_to    = cyc + RD_LAT;
            end
        end
        if (rq && cyc > busy_to) begin
            ack_cyc = cyc + 1; busy_from = cyc + 1; busy_to = INF;
            bank_m = id; burst_open = 1'b1;
        end
        step();
    endtask

    typedef struct {
        bit req; logic [1:0] rid; bit reb; bit rlast; logic [9:0] addr;
        bit e_ack; logic [3:0] e_cs; bit e_busy; bit e_rv;
    } vec_t;
    vec_t tbl[8];

    int acks;

    initial begin
        // single-beat transaction on bank 2, one row per cycle
        tbl[0] = '{1'b1, 2'd2, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 1'b1, 10'h010, 1'b0, 4'b0100, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1;
        req = 0; rid = 0; reb = 1; rlast = 0; addr = 0;
        req1 = 0; rid1 = 0; reb1 = 1; rlast1 = 0; addr1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_cs", mem_cs, 4'b0000);
        chk("rst_rdata", rdata, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; rid = tbl[i].rid; reb = tbl[i].reb;
            rlast = tbl[i].rlast; addr = tbl[i].addr;
            #1;
            chk("tbl_ack", ack, tbl[i].e_ack);
            chk("tbl_cs", mem_cs, tbl[i].e_cs);
            if (tbl[i].e_cs != 4'b0000) chk("tbl_maddr", mem_addr, tbl[i].addr);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_rvalid", rvalid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk("tbl_rdata", rdata, pat(2, 'h010));
            step();
        end
        e_rdata = pat(2, 'h010);

        // four back-to-back beats on bank 1; rid changes mid-burst must not matter
        tick(1, 2'd1, 1, 0, 0);
        tick(0, 2'd0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 2'd3, 0, (i == 3), 10'(i));
        repeat (5) tick(0, 2'd0, 1, 0, 0);

        // gapped burst: beats at offsets 0, 2, 5; req pulses in the gaps are ignored
        tick(1, 2'd0, 1, 0, 0);
        tick(0, 2'd0, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            tick((i == 1 || i == 4), 2'd2, !(i == 0 || i == 2 || i == 5), (i == 5 || i == 1), 10'(32 + i));
        repeat (5) tick(0, 2'd0, 1, 0, 0);

        // req held across a two-beat burst: second ack only after returning to IDLE
        acks = 0;
        for (int i = 0; i < 11; i++) begin
            tick((i <= 9), 2'(i), !(i == 2 || i == 3 || i == 9 || i == 10), (i == 3 || i == 10), 10'(64 + i));
            if (i < 7 && ack === 1'b1) acks++;
        end
        repeat (5) tick(0, 2'd0, 1, 0, 0);

        // reset during the second beat of a three-beat burst
        tick(1, 2'd3, 1, 0, 0);
        tick(0, 2'd0, 1, 0, 0);
        tick(0, 2'd0, 0, 0, 10'h100);
        req = 0; reb = 0; rlast = 0; addr = 10'h101;
        #1;
        chk("r38_cs_pre", mem_cs, 4'b1000);
        rst = 1'b1;
        #1;
        chk("r38_ack", ack, 1'b0);
        chk("r38_rvalid", rvalid, 1'b0);
        chk("r38_cs", mem_cs, 4'b0000);
        chk("r38_busy", busy, 1'b0);
        chk("r38_rdata", rdata, '0);
        model_reset();
        step();
        rst = 1'b0;
        repeat (6) tick(0, 2'd0, 0, 0, 10'h102);

        for (int n = 0; n < 1500; n++)
            tick(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), 10'($urandom_range(0, 1023)));
        repeat (8) tick(0, 2'd0, 1, 0, 0);

        // single-cycle latency build
        req1 = 0; reb1 = 0; addr1 = 10'h007;
        #1;
        chk("l1_idle_cs", mem_cs1, 4'b0000);
        step();
        req1 = 1; rid1 = 2'd3; reb1 = 0;
        #1;
        chk("l1_req_cs", mem_cs1, 4'b0000);
        step();
        req1 = 0; rid1 = 2'd0; reb1 = 0;
        #1;
        chk("l1_ack", ack1, 1'b1);
        chk("l1_grant_cs", mem_cs1, 4'b0000);
        step();
        reb1 = 0; rlast1 = 1; addr1 = 10'h155;
        #1;
        chk("l1_beat_cs", mem_cs1, 4'b1000);
        chk("l1_beat_maddr", mem_addr1, 10'h155);
        chk("l1_beat_rvalid", rvalid1, 1'b0);
        step();
        reb1 = 1; rlast1 = 0;
        #1;
        chk("l1_rvalid", rvalid1, 1'b1);
        chk("l1_rdata", rdata1, pat(3, 'h155));
        chk("l1_busy", busy1, 1'b1);
        step();
        #1;
        chk("l1_rvalid_off", rvalid1, 1'b0);
        chk("l1_idle", busy1, 1'b0);
        chk("l1_hold", rdata1, pat(3, 'h155));

        chk("r37_acks", 32'(acks), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
